// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing generator. Produces active-low HSync and
//               VSync, the current column/row, an active-video flag and a
//               one-clock frame-start strobe. Counting is qualified by a
//               pixel enable so the block runs from a native pixel clock or
//               from a faster system clock.
// Ports       : i_Clk         - single clock for all logic
//               i_Reset       - synchronous, active-high reset
//               i_Pix_En      - pixel-advance qualifier
//               o_HSync       - horizontal sync, active low
//               o_VSync       - vertical sync, active low
//               o_Col_Count   - current pixel column (10 bit)
//               o_Row_Count   - current line (10 bit)
//               o_Active      - high inside the visible area
//               o_Frame_Start - one-clock strobe when counts become (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
   parameter int TOTAL_COLS    = 800,
   parameter int TOTAL_ROWS    = 525,
   parameter int ACTIVE_COLS   = 640,
   parameter int ACTIVE_ROWS   = 480,
   parameter int H_FRONT_PORCH = 16,
   parameter int H_SYNC_WIDTH  = 96,
   parameter int V_FRONT_PORCH = 10,
   parameter int V_SYNC_WIDTH  = 2
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Pix_En,
   output logic       o_HSync,
   output logic       o_VSync,
   output logic [9:0] o_Col_Count,
   output logic [9:0] o_Row_Count,
   output logic       o_Active,
   output logic       o_Frame_Start
);

   // All decode thresholds held at the 10-bit count width.
   localparam logic [9:0] c_COL_LAST   = 10'(TOTAL_COLS - 1);
   localparam logic [9:0] c_ROW_LAST   = 10'(TOTAL_ROWS - 1);
   localparam logic [9:0] c_ACT_COLS   = 10'(ACTIVE_COLS);
   localparam logic [9:0] c_ACT_ROWS   = 10'(ACTIVE_ROWS);
   localparam logic [9:0] c_HS_START   = 10'(ACTIVE_COLS + H_FRONT_PORCH);
   localparam logic [9:0] c_HS_END     = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
   localparam logic [9:0] c_VS_START   = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
   localparam logic [9:0] c_VS_END     = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

   logic [9:0] r_col_q, w_col_d;
   logic [9:0] r_row_q, w_row_d;
   logic       r_hsync_q, w_hsync_d;
   logic       r_vsync_q, w_vsync_d;
   logic       r_active_q, w_active_d;
   logic       r_frame_start_q, w_frame_start_d;

   // Next-state: counts advance on enable, and every decoded output is
   // derived from the next count so all outputs describe the same pixel.
   always_comb begin
      w_col_d         = r_col_q;
      w_row_d         = r_row_q;
      w_hsync_d       = r_hsync_q;
      w_vsync_d       = r_vsync_q;
      w_active_d      = r_active_q;
      w_frame_start_d = 1'b0;   // strobe width is one clock regardless of enable duty

      if (i_Pix_En) begin
         if (r_col_q == c_COL_LAST) begin
            w_col_d = 10'd0;
            // Row wraps in the same edge as column; no (0,TOTAL_ROWS) state.
            if (r_row_q == c_ROW_LAST) begin
               w_row_d = 10'd0;
            end else begin
               w_row_d = r_row_q + 10'd1;
            end
         end else begin
            w_col_d = r_col_q + 10'd1;
         end

         w_hsync_d       = !((w_col_d >= c_HS_START) && (w_col_d < c_HS_END));
         w_vsync_d       = !((w_row_d >= c_VS_START) && (w_row_d < c_VS_END));
         w_active_d      = (w_col_d < c_ACT_COLS) && (w_row_d < c_ACT_ROWS);
         w_frame_start_d = (w_col_d == 10'd0) && (w_row_d == 10'd0);
      end
   end

   // Reset parks on the last blanking pixel so the first advance lands on (0,0).
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_col_q         <= c_COL_LAST;
         r_row_q         <= c_ROW_LAST;
         r_hsync_q       <= 1'b1;
         r_vsync_q       <= 1'b1;
         r_active_q      <= 1'b0;
         r_frame_start_q <= 1'b0;
      end else begin
         r_col_q         <= w_col_d;
         r_row_q         <= w_row_d;
         r_hsync_q       <= w_hsync_d;
         r_vsync_q       <= w_vsync_d;
         r_active_q      <= w_active_d;
         r_frame_start_q <= w_frame_start_d;
      end
   end

   assign o_Col_Count   = r_col_q;
   assign o_Row_Count   = r_row_q;
   assign o_HSync       = r_hsync_q;
   assign o_VSync       = r_vsync_q;
   assign o_Active      = r_active_q;
   assign o_Frame_Start = r_frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen using a reduced raster
//               (20x12 total, 12x8 active) so whole frames fit in a short run.
//               HSync low on cols 14..16, VSync low on rows 9..10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

   localparam int TC  = 20;
   localparam int TR  = 12;
   localparam int AC  = 12;
   localparam int AR  = 8;
   localparam int HFP = 2;
   localparam int HSW = 3;
   localparam int VFP = 1;
   localparam int VSW = 2;
   // Hand-computed sync windows for the reduced raster.
   localparam int HS_LO = 14;
   localparam int HS_HI = 16;
   localparam int VS_LO = 9;
   localparam int VS_HI = 10;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic [9:0] col;
      logic [9:0] row;
      logic       act;
      logic       fs;
   } out_t;

   logic       i_Clk = 1'b0;
   logic       i_Reset = 1'b1;
   logic       i_Pix_En = 1'b0;
   logic       o_HSync;
   logic       o_VSync;
   logic [9:0] o_Col_Count;
   logic [9:0] o_Row_Count;
   logic       o_Active;
   logic       o_Frame_Start;

   vga_sync_gen #(
      .TOTAL_COLS   (TC),
      .TOTAL_ROWS   (TR),
      .ACTIVE_COLS  (AC),
      .ACTIVE_ROWS  (AR),
      .H_FRONT_PORCH(HFP),
      .H_SYNC_WIDTH (HSW),
      .V_FRONT_PORCH(VFP),
      .V_SYNC_WIDTH (VSW)
   ) u_dut (
      .i_Clk        (i_Clk),
      .i_Reset      (i_Reset),
      .i_Pix_En     (i_Pix_En),
      .o_HSync      (o_HSync),
      .o_VSync      (o_VSync),
      .o_Col_Count  (o_Col_Count),
      .o_Row_Count  (o_Row_Count),
      .o_Active     (o_Active),
      .o_Frame_Start(o_Frame_Start)
   );

   always #5 i_Clk = ~i_Clk;

   out_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   m_col  = TC - 1;
   int   m_row  = TR - 1;
   out_t m_out;

   function automatic out_t dut_out();
      out_t o;
      o.hs  = o_HSync;
      o.vs  = o_VSync;
      o.col = o_Col_Count;
      o.row = o_Row_Count;
      o.act = o_Active;
      o.fs  = o_Frame_Start;
      return o;
   endfunction

   // Apply one clock of stimulus and queue the response expected after the edge.
   task automatic drive(input logic rst, input logic en);
      @(negedge i_Clk);
      i_Reset  = rst;
      i_Pix_En = en;
      if (rst) begin
         m_col = TC - 1;
         m_row = TR - 1;
         m_out = '{hs: 1'b1, vs: 1'b1, col: 10'(TC - 1), row: 10'(TR - 1), act: 1'b0, fs: 1'b0};
      end else if (en) begin
         m_col = m_col + 1;
         if (m_col == TC) begin
            m_col = 0;
            m_row = m_row + 1;
            if (m_row == TR) m_row = 0;
         end
         m_out.col = 10'(m_col);
         m_out.row = 10'(m_row);
         m_out.hs  = !(m_col >= HS_LO && m_col <= HS_HI);
         m_out.vs  = !(m_row >= VS_LO && m_row <= VS_HI);
         m_out.act = (m_col < AC) && (m_row < AR);
         m_out.fs  = (m_col == 0) && (m_row == 0);
      end else begin
         m_out.fs = 1'b0;
      end
      exp_q.push_back(m_out);
      @(posedge i_Clk);
      #2;
   endtask

   // Scoreboard monitor: one expected record per clock of stimulus.
   always @(posedge i_Clk) begin
      #1;
      if (exp_q.size() > 0) begin
         out_t e;
         out_t g;
         e = exp_q.pop_front();
         g = dut_out();
         n_vec++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t: got col=%0d row=%0d hs=%b vs=%b act=%b fs=%b, expected col=%0d row=%0d hs=%b vs=%b act=%b fs=%b",
                     $time, g.col, g.row, g.hs, g.vs, g.act, g.fs,
                     e.col, e.row, e.hs, e.vs, e.act, e.fs);
         end
      end
   end

   // Directed check against a hand-written constant.
   task automatic check_now(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   int fs_seen;
   int gap;
   int last_fs;

   initial begin
      m_out = '{hs: 1'b1, vs: 1'b1, col: 10'(TC - 1), row: 10'(TR - 1), act: 1'b0, fs: 1'b0};

      // Reset, including with enable high: reset has priority.
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      check_now("reset_col", int'(o_Col_Count), 19);
      check_now("reset_row", int'(o_Row_Count), 11);
      check_now("reset_hs_vs_act_fs", int'({o_HSync, o_VSync, o_Active, o_Frame_Start}), 4'b1100);

      // First advance lands on (0,0) with frame start and active.
      drive(1'b0, 1'b1);
      check_now("first_col", int'(o_Col_Count), 0);
      check_now("first_row", int'(o_Row_Count), 0);
      check_now("first_fs_act", int'({o_Frame_Start, o_Active}), 2'b11);

      // Continuous enable: frame start recurs every 240 clocks.
      fs_seen = 0;
      last_fs = 0;
      for (int i = 1; i <= 2 * TC * TR + 30; i++) begin
         drive(1'b0, 1'b1);
         if (o_Frame_Start) begin
            fs_seen++;
            gap = i - last_fs;
            last_fs = i;
            check_now("fs_period_cont", gap, 240);
         end
      end
      check_now("fs_count_cont", fs_seen, 2);

      // One enable in four: frame period 960 clocks, strobe still one clock.
      fs_seen = 0;
      last_fs = -1;
      for (int i = 0; i < 4 * TC * TR * 2 + 40; i++) begin
         drive(1'b0, (i % 4) == 0);
         if (o_Frame_Start) begin
            fs_seen++;
            if (last_fs >= 0) check_now("fs_period_div4", i - last_fs, 960);
            last_fs = i;
         end
      end
      check_now("fs_count_div4", fs_seen, 2);

      // Reset mid-frame at (5,4), then release.
      for (int i = 0; i < 2 * TC * TR && !(m_col == 5 && m_row == 4); i++) drive(1'b0, 1'b1);
      check_now("reach_5_4", int'({o_Row_Count, o_Col_Count}), (4 << 10) | 5);
      drive(1'b1, 1'b1);
      check_now("midreset_col_row", int'({o_Row_Count, o_Col_Count}), (11 << 10) | 19);
      check_now("midreset_flags", int'({o_HSync, o_VSync, o_Active}), 3'b110);
      drive(1'b0, 1'b1);
      check_now("release_origin", int'({o_Row_Count, o_Col_Count, o_Frame_Start}), 1);

      // Freeze one column before the HSync window, then resume.
      for (int i = 0; i < 2 * TC && m_col != HS_LO - 1; i++) drive(1'b0, 1'b1);
      for (int i = 0; i < 60; i++) drive(1'b0, 1'b0);
      check_now("frozen_col", int'(o_Col_Count), 13);
      check_now("frozen_hs", int'(o_HSync), 1);
      drive(1'b0, 1'b1);
      check_now("resume_col", int'(o_Col_Count), 14);
      check_now("resume_hs", int'(o_HSync), 0);

      // Run through the VSync rows with continuous enable.
      for (int i = 0; i < TC * TR + 10; i++) drive(1'b0, 1'b1);

      @(posedge i_Clk);
      #3;
      check_now("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator driving the VGA connector and the game pipeline. Produces the horizontal/vertical sync pulses plus aligned pixel column/row counts, an active-video flag and a frame-start strobe. Its outputs are the source that the sync-to-count stage and the game/draw logic consume. Counters advance on a pixel-enable qualifier, so one design supports both a native 25 MHz pixel clock and a faster system clock.

## Interface
- TOTAL_COLS, 800, pixels per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- H_FRONT_PORCH, 16, pixels between active video and HSync pulse
- H_SYNC_WIDTH, 96, HSync pulse width in pixels
- V_FRONT_PORCH, 10, lines between active video and VSync pulse
- V_SYNC_WIDTH, 2, VSync pulse width in lines
- i_Clk  in  1  single clock for all logic
- i_Reset  in  1  synchronous, active-high reset
- i_Pix_En  in  1  pixel-advance qualifier; tie high for one pixel per clock
- o_HSync  out  1  horizontal sync, active-low pulse
- o_VSync  out  1  vertical sync, active-low pulse
- o_Col_Count  out  10  current pixel column, 0..TOTAL_COLS-1
- o_Row_Count  out  10  current line, 0..TOTAL_ROWS-1
- o_Active  out  1  high when col < ACTIVE_COLS and row < ACTIVE_ROWS
- o_Frame_Start  out  1  one-clock strobe when the counts become (0,0)

## Operation
- All outputs are registers. They describe the same pixel in the same cycle, so there is no skew between sync, counts and active.
- Reset values: o_Col_Count = TOTAL_COLS-1 (799), o_Row_Count = TOTAL_ROWS-1 (524), o_HSync = 1, o_VSync = 1, o_Active = 0, o_Frame_Start = 0. This parks the counters on the last blanking pixel so the first advance lands on (0,0).
- Advance happens only on a clock where i_Pix_En = 1 and i_Reset = 0:
  - col increments.
  - At col = TOTAL_COLS-1, col wraps to 0 and row increments.
  - At row = TOTAL_ROWS-1 with col = TOTAL_COLS-1, both wrap to 0.
- With i_Pix_En = 0, all outputs hold, except o_Frame_Start, which clears to 0.
- HSync is low for ACTIVE_COLS+H_FRONT_PORCH ≤ col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH, i.e. cols 656..751, and high otherwise. It depends on col only and toggles on every line, including vertical blanking.
- VSync is low for ACTIVE_ROWS+V_FRONT_PORCH ≤ row < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH, i.e. rows 490..491, over all columns of those rows.
- Back porch is implicit: whatever remains of TOTAL after active + front porch + sync (48 pixels, 33 lines by default).
- o_Frame_Start is 1 for exactly one i_Clk cycle: the cycle in which the registered counts first show (0,0). Its width does not depend on the i_Pix_En duty.
- Sync, active and frame-start values are decoded from the next-count value, so they are registered together with the counts.
- Width rules:
  - Counts are 10-bit unsigned; TOTAL_COLS and TOTAL_ROWS must be ≤ 1024.
  - Comparisons are unsigned and computed at the 10-bit count width.
  - ACTIVE + FRONT_PORCH + SYNC_WIDTH must be ≤ TOTAL on each axis.

## Timing
- Latency: an i_Pix_En cycle at edge N updates all outputs at edge N+1.
- With i_Pix_En constant high:
  - Line period = 800 clocks; frame period = 420000 clocks.
  - HSync low for 96 consecutive clocks per line.
  - VSync low for 1600 consecutive clocks per frame.
- VSync falls at (col 0, row 490) and rises at (col 0, row 492).
- Reset priority:
  - i_Reset overrides i_Pix_En.
  - Reset asserted mid-frame restores the reset values at the next edge, whatever the current position.
  - The first advance after reset is released yields (0,0) with o_Frame_Start = 1 and o_Active = 1.
- Simultaneous column and row wrap at (799,524) occurs in a single edge, with no intermediate (0,525) state.

## Test plan
- Reset, then i_Pix_En = 1 continuously → first post-reset cycle shows counts (0,0), o_Frame_Start = 1, o_Active = 1. o_Frame_Start recurs every 420000 clocks.
- Same stimulus, measure HSync → falls when col = 656, low for exactly 96 clocks, 800-clock period on every row 0..524.
- Same stimulus, measure VSync and active → VSync low for exactly 1600 clocks starting at (0,490). o_Active high for 307200 clocks per frame, never when col ≥ 640 or row ≥ 480.
- i_Pix_En high one clock in four → counts advance once per 4 clocks. Frame period is 1680000 clocks. o_Frame_Start is still exactly 1 clock wide. Outputs are stable between advances.
- Reset asserted while counts are (300,200) → next edge gives 799/524, syncs 1, active 0. Release with i_Pix_En = 1 → following edge gives (0,0).
- i_Pix_En held low for 1000 clocks mid-line at col 655 → all outputs frozen. The first enable moves to col 656 with o_HSync = 0 on that same cycle.
